// File: rtl/regfile_cmd_seq_pkg.sv
// regfile_cmd_seq_pkg: shared encodings and default sizes for the
// register-file command sequencer (commands, FSM states, widths).
package regfile_cmd_seq_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 3;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_MOVE = 2'd1,
    OP_LOAD = 2'd2,
    OP_READ = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_cmd_seq_if.sv
// regfile_cmd_seq_if: command stream and response stream between a host
// (master) and the register-file sequencer (slave).
interface regfile_cmd_seq_if #(
  parameter int DW = regfile_cmd_seq_pkg::DEF_DW,
  parameter int AW = regfile_cmd_seq_pkg::DEF_AW
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rs;
  logic [AW-1:0] cmd_rd;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_reg;

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rd, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_reg
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rd, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_reg
  );
endinterface

// File: rtl/regfile_cmd_seq_rsp.sv
// regfile_cmd_seq_rsp: one-entry holding register for READ results.
// A capture loads the entry; it stays valid and stable until the
// consumer accepts it with ready.
module regfile_cmd_seq_rsp #(
  parameter int DW = regfile_cmd_seq_pkg::DEF_DW,
  parameter int AW = regfile_cmd_seq_pkg::DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture,
  input  logic [DW-1:0] cap_data,
  input  logic [AW-1:0] cap_reg,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] idx
);

  // Load a new result on capture, otherwise drop valid once it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      idx   <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= cap_data;
      idx   <= cap_reg;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_cmd_seq.sv
// regfile_cmd_seq: turns a valid/ready command stream (NOP/MOVE/LOAD/READ)
// into registered strobes for the 8x16 register file and returns READ
// results through a one-entry response register.
// Optional feature macro: REGSEQ_STATS_EN adds stat_cmds/stat_reads counters.
module regfile_cmd_seq
  import regfile_cmd_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_cmd_seq_if.slave    bus,
  output logic                rf_move,
  output logic                rf_in,
  output logic [AW-1:0]       rf_rs,
  output logic [AW-1:0]       rf_rd,
  output logic [DW-1:0]       rf_data_in,
  input  logic [DW-1:0]       rf_data_out
`ifdef REGSEQ_STATS_EN
  ,
  output logic [15:0]         stat_cmds,
  output logic [15:0]         stat_reads
`endif
);

  state_t        state, state_d;
  logic          move_d;
  logic          in_d;
  logic [AW-1:0] rs_d;
  logic [AW-1:0] rd_d;
  logic [DW-1:0] data_d;
  logic          capture;
  logic          accept;
  logic          rsp_valid_int;
  logic [DW-1:0] rsp_data_int;
  logic [AW-1:0] rsp_reg_int;

  // New commands only in IDLE/WR and only while no response is pending,
  // so the response register can never be overwritten.
  assign bus.cmd_ready = ((state == IDLE) || (state == WR)) && !rsp_valid_int;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // Next-state and next-strobe decode; index/data registers hold by default.
  always_comb begin
    state_d = IDLE;
    move_d  = 1'b0;
    in_d    = 1'b0;
    rs_d    = rf_rs;
    rd_d    = rf_rd;
    data_d  = rf_data_in;
    capture = 1'b0;
    case (state)
      IDLE, WR: begin
        if (accept) begin
          case (op_t'(bus.cmd_op))
            OP_MOVE: begin
              move_d  = 1'b1;
              rs_d    = bus.cmd_rs;
              rd_d    = bus.cmd_rd;
              state_d = WR;
            end
            OP_LOAD: begin
              in_d    = 1'b1;
              rd_d    = bus.cmd_rd;
              data_d  = bus.cmd_data;
              state_d = WR;
            end
            OP_READ: begin
              move_d  = 1'b1;
              rs_d    = bus.cmd_rs;
              rd_d    = bus.cmd_rs;
              state_d = RD1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RD1: begin
        move_d  = 1'b1;
        state_d = RD2;
      end
      RD2: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register-file drive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rf_move    <= 1'b0;
      rf_in      <= 1'b0;
      rf_rs      <= '0;
      rf_rd      <= '0;
      rf_data_in <= '0;
    end else begin
      state      <= state_d;
      rf_move    <= move_d;
      rf_in      <= in_d;
      rf_rs      <= rs_d;
      rf_rd      <= rd_d;
      rf_data_in <= data_d;
    end
  end

  regfile_cmd_seq_rsp #(.DW(DW), .AW(AW)) u_rsp (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .cap_data (rf_data_out),
    .cap_reg  (rf_rs),
    .ready    (bus.rsp_ready),
    .valid    (rsp_valid_int),
    .data     (rsp_data_int),
    .idx      (rsp_reg_int)
  );

  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_data_int;
  assign bus.rsp_reg   = rsp_reg_int;

`ifdef REGSEQ_STATS_EN
  // Count accepted non-NOP commands and delivered responses; both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmds  <= 16'd0;
      stat_reads <= 16'd0;
    end else begin
      if (accept && (op_t'(bus.cmd_op) != OP_NOP))
        stat_cmds <= stat_cmds + 16'd1;
      if (rsp_valid_int && bus.rsp_ready)
        stat_reads <= stat_reads + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_cmd_seq.sv
// tb_regfile_cmd_seq: bench for regfile_cmd_seq with a behavioural 8x16
// register file (move/in strobes, tristated data_out).
module tb_regfile_cmd_seq;
  import regfile_cmd_seq_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [15:0] data;
    logic [15:0] exp_data;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        rf_move;
  logic        rf_in;
  logic [2:0]  rf_rs;
  logic [2:0]  rf_rd;
  logic [15:0] rf_data_in;
  wire  [15:0] rf_data_out;
`ifdef REGSEQ_STATS_EN
  logic [15:0] stat_cmds;
  logic [15:0] stat_reads;
`endif

  logic [15:0] rf_mem [8];
  logic [15:0] rf_latch;

  int checks = 0;
  int errors = 0;
  logic [2:0] last_rs;
  vec_t vecs [10];

  regfile_cmd_seq_if #(.DW(16), .AW(3)) bus ();

  regfile_cmd_seq #(.DW(16), .AW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .rf_move     (rf_move),
    .rf_in       (rf_in),
    .rf_rs       (rf_rs),
    .rf_rd       (rf_rd),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out)
`ifdef REGSEQ_STATS_EN
    ,
    .stat_cmds   (stat_cmds),
    .stat_reads  (stat_reads)
`endif
  );

  // Clock generation, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: load or move on the edge; a move also latches the
  // source word, which drives data_out while either strobe is high.
  always @(posedge clk) begin
    if (rf_in) begin
      rf_mem[rf_rd] <= rf_data_in;
    end else if (rf_move) begin
      rf_mem[rf_rd] <= rf_mem[rf_rs];
      rf_latch      <= rf_mem[rf_rs];
    end
  end

  assign rf_data_out = (rf_move || rf_in) ? rf_latch : 16'hzzzz;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command and check its strobes; READs run to the handshake.
  task automatic applyStimulus(input vec_t v);
    int wait_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_rs    = v.rs;
    bus.cmd_rd    = v.rd;
    bus.cmd_data  = v.data;
    wait_cnt = 0;
    while (!bus.cmd_ready && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    if (!bus.cmd_ready) checkOutput("cmd_ready_wait", bus.cmd_ready, 1);
    step();
    case (v.op)
      2'd1: begin
        checkOutput("move_strobe", {rf_move, rf_in}, 2'b10);
        checkOutput("move_rs", rf_rs, v.rs);
        checkOutput("move_rd", rf_rd, v.rd);
        checkOutput("ready_in_wr", bus.cmd_ready, 1);
        last_rs = v.rs;
      end
      2'd2: begin
        checkOutput("load_strobe", {rf_move, rf_in}, 2'b01);
        checkOutput("load_rd", rf_rd, v.rd);
        checkOutput("load_data", rf_data_in, v.data);
        checkOutput("load_rs_hold", rf_rs, last_rs);
        checkOutput("ready_in_wr", bus.cmd_ready, 1);
      end
      2'd3: begin
        bus.cmd_valid = 1'b0;
        last_rs = v.rs;
        checkOutput("rd1_strobe", {rf_move, rf_in}, 2'b10);
        checkOutput("rd1_rs", rf_rs, v.rs);
        checkOutput("rd1_rd", rf_rd, v.rs);
        checkOutput("rd1_ready", bus.cmd_ready, 0);
        step();
        checkOutput("rd2_strobe", {rf_move, rf_in}, 2'b10);
        checkOutput("rd2_rsp_valid", bus.rsp_valid, 0);
        step();
        checkOutput("rsp_valid", bus.rsp_valid, 1);
        checkOutput("rsp_data", bus.rsp_data, v.exp_data);
        checkOutput("rsp_reg", bus.rsp_reg, v.rs);
        checkOutput("rsp_strobe_drop", {rf_move, rf_in}, 2'b00);
        step();
        checkOutput("rsp_cleared", bus.rsp_valid, 0);
        checkOutput("ready_after_rsp", bus.cmd_ready, 1);
      end
      default: begin
        checkOutput("nop_strobe", {rf_move, rf_in}, 2'b00);
      end
    endcase
  endtask

  initial begin
    vec_t v;
    logic [15:0] held;

    vecs[0] = '{op: 2'd2, rs: 3'd0, rd: 3'd2, data: 16'h1234, exp_data: 16'h0000};
    vecs[1] = '{op: 2'd3, rs: 3'd2, rd: 3'd0, data: 16'h0000, exp_data: 16'h1234};
    vecs[2] = '{op: 2'd2, rs: 3'd0, rd: 3'd4, data: 16'h0303, exp_data: 16'h0000};
    vecs[3] = '{op: 2'd1, rs: 3'd4, rd: 3'd5, data: 16'h0000, exp_data: 16'h0000};
    vecs[4] = '{op: 2'd3, rs: 3'd5, rd: 3'd0, data: 16'h0000, exp_data: 16'h0303};
    vecs[5] = '{op: 2'd2, rs: 3'd0, rd: 3'd7, data: 16'hBEEF, exp_data: 16'h0000};
    vecs[6] = '{op: 2'd3, rs: 3'd7, rd: 3'd0, data: 16'h0000, exp_data: 16'hBEEF};
    vecs[7] = '{op: 2'd2, rs: 3'd0, rd: 3'd0, data: 16'hFFFF, exp_data: 16'h0000};
    vecs[8] = '{op: 2'd1, rs: 3'd0, rd: 3'd3, data: 16'h0000, exp_data: 16'h0000};
    vecs[9] = '{op: 2'd3, rs: 3'd3, rd: 3'd0, data: 16'h0000, exp_data: 16'hFFFF};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_rs    = 3'd0;
    bus.cmd_rd    = 3'd0;
    bus.cmd_data  = 16'h0000;
    bus.rsp_ready = 1'b1;
    last_rs       = 3'd0;

    // Reset state
    step();
    step();
    checkOutput("reset_strobes", {rf_move, rf_in}, 2'b00);
    checkOutput("reset_rs_rd", {rf_rs, rf_rd}, 6'd0);
    checkOutput("reset_data_in", rf_data_in, 16'h0000);
    checkOutput("reset_rsp", {bus.rsp_valid, bus.rsp_reg, bus.rsp_data}, 20'd0);
    rst_n = 1'b1;
    step();
    checkOutput("reset_cmd_ready", bus.cmd_ready, 1);

    // Table-driven command sequence; writes chain back-to-back
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      applyStimulus(v);
    end
    bus.cmd_valid = 1'b0;
    step();

    // READ r2 with the consumer stalled for 10 cycles
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd3;
    bus.cmd_rs    = 3'd2;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    held = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", bus.rsp_valid, 1);
      checkOutput("stall_data", bus.rsp_data, held);
      checkOutput("stall_reg", bus.rsp_reg, 3'd2);
      checkOutput("stall_ready", bus.cmd_ready, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    checkOutput("stall_release_valid", bus.rsp_valid, 0);
    checkOutput("stall_release_ready", bus.cmd_ready, 1);

    // NOP stream
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd0;
      checkOutput("nop_ready", bus.cmd_ready, 1);
      step();
      checkOutput("nop_stream_strobe", {rf_move, rf_in}, 2'b00);
    end
    bus.cmd_valid = 1'b0;
    step();

    // Reset asserted during RD2 of a READ
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd3;
    bus.cmd_rs    = 3'd7;
    step();
    bus.cmd_valid = 1'b0;
    step();
    checkOutput("pre_reset_rd2", rf_move, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_move", rf_move, 0);
    checkOutput("midreset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("midreset_rs_rd", {rf_rs, rf_rd}, 6'd0);
    last_rs = 3'd0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("no_rsp_after_reset", bus.rsp_valid, 0);
    end
    checkOutput("ready_after_reset", bus.cmd_ready, 1);

`ifdef REGSEQ_STATS_EN
    // Statistics: 3 LOADs, 1 NOP, 2 READs
    checkOutput("stats_reset", {stat_cmds, stat_reads}, 32'd0);
    v = '{op: 2'd2, rs: 3'd0, rd: 3'd1, data: 16'h0011, exp_data: 16'h0000};
    applyStimulus(v);
    v = '{op: 2'd2, rs: 3'd0, rd: 3'd6, data: 16'h0660, exp_data: 16'h0000};
    applyStimulus(v);
    v = '{op: 2'd2, rs: 3'd0, rd: 3'd2, data: 16'h2222, exp_data: 16'h0000};
    applyStimulus(v);
    v = '{op: 2'd0, rs: 3'd0, rd: 3'd0, data: 16'h0000, exp_data: 16'h0000};
    applyStimulus(v);
    v = '{op: 2'd3, rs: 3'd1, rd: 3'd0, data: 16'h0000, exp_data: 16'h0011};
    applyStimulus(v);
    v = '{op: 2'd3, rs: 3'd6, rd: 3'd0, data: 16'h0000, exp_data: 16'h0660};
    applyStimulus(v);
    bus.cmd_valid = 1'b0;
    step();
    checkOutput("stat_cmds", stat_cmds, 16'd5);
    checkOutput("stat_reads", stat_reads, 16'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_cmd_seq.md
Name: regfile_cmd_seq

Overview:
- Initiator that drives the 8x16 register-file command interface (move/in/rs/rd/data_in, tristated data_out) from a valid/ready command stream.
- Converts LOAD, MOVE and READ commands into correctly timed register-file strobes.
- Returns READ results on a valid/ready response port.
- Sits between a host or test sequencer and the register file; it is the only driver of the register-file control pins.

Parameters:
- DW, 16, data width; must match the register-file word width.
- AW, 3, register index width (2**AW registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_op  in  2  0=NOP, 1=MOVE, 2=LOAD, 3=READ.
- cmd_rs  in  AW  source register (MOVE, READ).
- cmd_rd  in  AW  destination register (MOVE, LOAD).
- cmd_data  in  DW  LOAD immediate.
- rsp_valid  out  1  READ result held.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DW  READ result.
- rsp_reg  out  AW  index that was read.
- rf_move  out  1  register-file move strobe.
- rf_in  out  1  register-file load strobe.
- rf_rs  out  AW  register-file source index.
- rf_rd  out  AW  register-file destination index.
- rf_data_in  out  DW  register-file load data.
- rf_data_out  in  DW  register-file output; valid only while rf_move or rf_in is high.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rf_move=rf_in=0; rf_rs=rf_rd=0; rf_data_in=0; rsp_valid=0; rsp_data=0; rsp_reg=0. All of these are forced immediately, mid-operation included.
- Any in-flight READ is dropped on reset. No response is ever produced for it.
- All rf_* outputs and all rsp_* outputs are registered.
- cmd_ready = (state==IDLE || state==WR) && !rsp_valid. It is combinational from state, never from cmd_op.
- States: IDLE, WR, RD1, RD2.
- Accept NOP: no strobe; next state IDLE.
- Accept MOVE: next cycle rf_move=1, rf_rs=cmd_rs, rf_rd=cmd_rd; state WR.
- Accept LOAD: next cycle rf_in=1, rf_rd=cmd_rd, rf_data_in=cmd_data; rf_rs holds its previous value; state WR.
- WR lasts one cycle, then strobes drop. A command accepted in WR chains back-to-back, giving one write per cycle.
- Accept READ of index r: RD1 drives rf_move=1, rf_rs=rf_rd=r. The self-move is harmless and makes the register file latch registers[r].
- RD2 holds the same strobes so data_out is enabled.
- At the edge ending RD2: rsp_data<=rf_data_out, rsp_reg<=r, rsp_valid<=1, strobes drop, state IDLE.
- READ latency: acceptance edge to rsp_valid rising is exactly 3 edges. cmd_ready is low during RD1/RD2.
- Read-after-write: a READ accepted in WR sees the preceding write, because RD1's edge samples after WR's edge commits. No forwarding logic is required.
- rsp_valid stays high and rsp_data/rsp_reg stay stable until rsp_ready; it clears on the edge where rsp_valid && rsp_ready.
- cmd_ready stays low while rsp_valid=1. It can rise in the cycle after the response handshake.
- rf_move and rf_in are never high in the same cycle.
- Index wrap: indices are AW bits wide, so there is no out-of-range case.

Optional Feature:
- Macro REGSEQ_STATS_EN.
- Defined: adds output stat_cmds[15:0], which counts accepted non-NOP commands, and output stat_reads[15:0], which counts delivered responses.
  - Both counters wrap 0xFFFF to 0.
  - Both reset to 0 asynchronously.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package regfile_cmd_seq_pkg holds:
  - op encodings OP_NOP/OP_MOVE/OP_LOAD/OP_READ;
  - state encoding IDLE/WR/RD1/RD2;
  - DW/AW defaults.
- Sub-module regfile_cmd_seq_rsp: the one-entry response holding register with its valid/ready handshake.
- The top level holds the FSM and the rf_* drive registers.
- The bench instantiates the sequencer together with the existing register-file module.

Test Plan:
- Reset mid-READ: assert rst_n=0 during RD2 -> rf_move=0 and rsp_valid=0 immediately; no response appears after rst_n=1.
- LOAD r2=0x1234, then READ r2 with rsp_ready=1 -> rsp_valid rises 3 edges after the READ is accepted; rsp_data=0x1234, rsp_reg=2.
- Back-to-back LOAD r4=0x0303, MOVE r4->r5, READ r5 -> writes issue one per cycle; rsp_data=0x0303, rsp_reg=5.
- READ r2 with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stay stable; cmd_ready=0 throughout; cmd_ready=1 one cycle after the handshake.
- NOP stream of 4 commands -> rf_move=rf_in=0 throughout; cmd_ready remains 1.
- With REGSEQ_STATS_EN defined: 3 LOADs, 1 NOP, 2 READs -> stat_cmds=5, stat_reads=2.
